// File: rtl/vpu_fp_cmp_arbiter.sv
// Round-robin front end that shares one fixed-latency floating_point_cmp core between
// NUM_REQ requesters, tracks in-flight ops by tag and returns flags plus max(A,B).
module vpu_fp_cmp_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int CMP_LATENCY   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [3:0]                         rsp_flags_o,
  output logic [OPERAND_WIDTH-1:0]           rsp_max_o,
  output logic                               cmp_tvalid_o,
  output logic [OPERAND_WIDTH-1:0]           cmp_a_tdata_o,
  output logic [OPERAND_WIDTH-1:0]           cmp_b_tdata_o,
  input  logic                               cmp_result_tvalid_i,
  input  logic [3:0]                         cmp_result_tdata_i,
  output logic                               err_o
);

  localparam int IDW    = $clog2(NUM_REQ);
  localparam int SUPP_W = $clog2(CMP_LATENCY + 2);

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]           ptr;
  logic [IDW-1:0]           ptr_next;
  logic [IDW:0]             arb_cand;
  logic                     grant_vld;
  logic [IDW-1:0]           grant_id;
  logic                     handshake;
  logic [OPERAND_WIDTH-1:0] grant_a;
  logic [OPERAND_WIDTH-1:0] grant_b;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand = {1'b0, ptr} + (IDW+1)'(k);
      if (arb_cand >= (IDW+1)'(NUM_REQ)) begin
        arb_cand = arb_cand - (IDW+1)'(NUM_REQ);
      end
      if (!grant_vld && req_valid_i[arb_cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = arb_cand[IDW-1:0];
      end
    end
  end

  // No grants while reset is asserted, so a handshake can never be silently lost.
  assign handshake   = grant_vld & rst_n;
  assign req_ready_o = handshake ? (NUM_REQ'(1) << grant_id) : '0;
  assign ptr_next    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign grant_a     = req_a_i[grant_id*OPERAND_WIDTH +: OPERAND_WIDTH];
  assign grant_b     = req_b_i[grant_id*OPERAND_WIDTH +: OPERAND_WIDTH];

  // ---------------------------------------------------------------------------
  // Issue register towards the core
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] issue_id;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr           <= '0;
      issue_id      <= '0;
      cmp_tvalid_o  <= 1'b0;
      cmp_a_tdata_o <= '0;
      cmp_b_tdata_o <= '0;
    end else begin
      cmp_tvalid_o <= handshake;
      if (handshake) begin
        ptr           <= ptr_next;
        issue_id      <= grant_id;
        cmp_a_tdata_o <= grant_a;
        cmp_b_tdata_o <= grant_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe: entry k is visible k+1 cycles after its issue cycle, so the head
  // entry lines up with the core result CMP_LATENCY cycles after cmp_tvalid_o.
  // ---------------------------------------------------------------------------
  logic [CMP_LATENCY-1:0]   pipe_vld;
  logic [IDW-1:0]           pipe_id [CMP_LATENCY];
  logic [OPERAND_WIDTH-1:0] pipe_a  [CMP_LATENCY];
  logic [OPERAND_WIDTH-1:0] pipe_b  [CMP_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= cmp_tvalid_o;
      for (int i = 1; i < CMP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    pipe_id[0] <= issue_id;
    pipe_a[0]  <= cmp_a_tdata_o;
    pipe_b[0]  <= cmp_b_tdata_o;
    for (int i = 1; i < CMP_LATENCY; i++) begin
      pipe_id[i] <= pipe_id[i-1];
      pipe_a[i]  <= pipe_a[i-1];
      pipe_b[i]  <= pipe_b[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Response and protocol checking
  // ---------------------------------------------------------------------------
  logic                     head_vld;
  logic [IDW-1:0]           head_id;
  logic [OPERAND_WIDTH-1:0] head_a;
  logic [OPERAND_WIDTH-1:0] head_b;
  logic                     rsp_fire;
  logic                     result_missing;
  logic                     result_stray;
  logic [SUPP_W-1:0]        supp_cnt;

  assign head_vld = pipe_vld[CMP_LATENCY-1];
  assign head_id  = pipe_id[CMP_LATENCY-1];
  assign head_a   = pipe_a[CMP_LATENCY-1];
  assign head_b   = pipe_b[CMP_LATENCY-1];

  assign rsp_fire       = head_vld & cmp_result_tvalid_i;
  assign result_missing = head_vld & ~cmp_result_tvalid_i;
  // The core keeps running through our reset; its leftovers arrive inside the suppression window.
  assign result_stray   = ~head_vld & cmp_result_tvalid_i & (supp_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_o <= '0;
      rsp_flags_o <= '0;
      rsp_max_o   <= '0;
      err_o       <= 1'b0;
      supp_cnt    <= SUPP_W'(CMP_LATENCY + 1);
    end else begin
      if (supp_cnt != '0) begin
        supp_cnt <= supp_cnt - 1'b1;
      end
      rsp_valid_o <= rsp_fire ? (NUM_REQ'(1) << head_id) : '0;
      if (rsp_fire) begin
        rsp_flags_o <= cmp_result_tdata_i;
        rsp_max_o   <= cmp_result_tdata_i[1] ? head_b : head_a;
      end
      if (result_missing || result_stray) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vpu_fp_cmp_arbiter.sv
// Directed bench for vpu_fp_cmp_arbiter with a fixed-latency comparator standing in for the core.
module tb_vpu_fp_cmp_arbiter;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [3:0]      rsp_flags;
  logic [W-1:0]    rsp_max;
  logic            cmp_tvalid;
  logic [W-1:0]    cmp_a;
  logic [W-1:0]    cmp_b;
  logic            res_tvalid;
  logic [3:0]      res_tdata;
  logic            err;

  int n_chk  = 0;
  int n_fail = 0;

  // Core stand-in: never reset, like the real IP.
  logic [LAT-1:0] core_v = '0;
  logic [3:0]     core_fl [LAT];
  logic           core_mute = 1'b0;
  logic           inj = 1'b0;

  // Test-2 operands: A=1.0 for all, B = 2.0, 0.5, 1.0, -1.0.
  logic [W-1:0] tb_b   [NR] = '{32'h40000000, 32'h3F000000, 32'h3F800000, 32'hBF800000};
  logic [3:0]   exp_fl [NR] = '{4'b0010, 4'b0100, 4'b0001, 4'b0100};
  logic [W-1:0] exp_mx [NR] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};

  vpu_fp_cmp_arbiter #(.NUM_REQ(NR), .OPERAND_WIDTH(W), .CMP_LATENCY(LAT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_i         (req_valid),
    .req_a_i             (req_a),
    .req_b_i             (req_b),
    .req_ready_o         (req_ready),
    .rsp_valid_o         (rsp_valid),
    .rsp_flags_o         (rsp_flags),
    .rsp_max_o           (rsp_max),
    .cmp_tvalid_o        (cmp_tvalid),
    .cmp_a_tdata_o       (cmp_a),
    .cmp_b_tdata_o       (cmp_b),
    .cmp_result_tvalid_i (res_tvalid),
    .cmp_result_tdata_i  (res_tdata),
    .err_o               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] fp_cmp(input logic [31:0] a, input logic [31:0] b);
    logic a_lt;
    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return 4'b1000;
    if (a == b || (a[30:0] == 31'd0 && b[30:0] == 31'd0)) return 4'b0001;
    if (a[31] != b[31]) a_lt = a[31];
    else if (!a[31])    a_lt = a[30:0] < b[30:0];
    else                a_lt = a[30:0] > b[30:0];
    return a_lt ? 4'b0010 : 4'b0100;
  endfunction

  always @(posedge clk) begin
    core_v     <= {core_v[LAT-2:0], cmp_tvalid};
    core_fl[0] <= fp_cmp(cmp_a, cmp_b);
    for (int i = 1; i < LAT; i++) core_fl[i] <= core_fl[i-1];
  end
  assign res_tvalid = (core_v[LAT-1] & ~core_mute) | inj;
  assign res_tdata  = core_fl[LAT-1];

  // Advance to just after the next rising edge; inputs are driven here, checks follow after #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = 32'h3F800000;
      req_b[i*W +: W] = tb_b[i];
    end
    repeat (4) step();
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_chk++; if (cmp_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_tvalid got=%b exp=0", cmp_tvalid); end
    n_chk++; if (cmp_a !== 32'h0 || cmp_b !== 32'h0) begin n_fail++; $display("FAIL reset_cmp_data got=%h/%h exp=0/0", cmp_a, cmp_b); end
    n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    n_chk++; if (rsp_flags !== 4'b0000 || rsp_max !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%b/%h exp=0000/0", rsp_flags, rsp_max); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    req_valid = 4'b0000;
    step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_single();
    step();
    req_valid = 4'b0001;
    req_a[0 +: W] = 32'h40400000;
    req_b[0 +: W] = 32'h40A00000;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    n_chk++; if (cmp_tvalid !== 1'b1 || cmp_a !== 32'h40400000 || cmp_b !== 32'h40A00000) begin
      n_fail++; $display("FAIL t1_issue got=%b %h %h exp=1 40400000 40a00000", cmp_tvalid, cmp_a, cmp_b); end
    step(); #1;
    n_chk++; if (cmp_tvalid !== 1'b0 || cmp_a !== 32'h40400000) begin
      n_fail++; $display("FAIL t1_idle got=%b %h exp=0 40400000", cmp_tvalid, cmp_a); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL t1_rsp_early got=%b exp=0000", rsp_valid); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0001 || rsp_flags !== 4'b0010 || rsp_max !== 32'h40A00000) begin
      n_fail++; $display("FAIL t1_rsp got=%b %b %h exp=0001 0010 40a00000", rsp_valid, rsp_flags, rsp_max); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0000 || rsp_flags !== 4'b0010 || rsp_max !== 32'h40A00000) begin
      n_fail++; $display("FAIL t1_hold got=%b %b %h exp=0000 0010 40a00000", rsp_valid, rsp_flags, rsp_max); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = 32'h3F800000;
      req_b[i*W +: W] = tb_b[i];
    end
    rst_n = 1'b0;
    req_valid = 4'b0000;
    repeat (3) step();
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin
        step();
        req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      end
      #1;
      if (c < 6) begin
        n_chk++; if (req_ready !== (4'b0001 << (c % 4))) begin
          n_fail++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << (c % 4)); end
      end
      if (c >= 4 && c < 10) begin
        n_chk++; if (rsp_valid !== (4'b0001 << ((c - 4) % 4)) || rsp_flags !== exp_fl[(c-4)%4]
                     || rsp_max !== exp_mx[(c-4)%4]) begin
          n_fail++; $display("FAIL b2b_rsp c=%0d got=%b %b %h exp=%b %b %h", c, rsp_valid, rsp_flags, rsp_max,
                             4'b0001 << ((c - 4) % 4), exp_fl[(c-4)%4], exp_mx[(c-4)%4]); end
      end else begin
        n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL b2b_rsp_idle c=%0d got=%b exp=0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_rr_skip();
    step(); req_valid = 4'b0100; #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rr_g2 got=%b exp=0100", req_ready); end
    step(); req_valid = 4'b1010; #1;
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_g3 got=%b exp=1000", req_ready); end
    step(); #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_g1 got=%b exp=0010", req_ready); end
    step(); req_valid = 4'b0000;
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0100 || rsp_max !== exp_mx[2]) begin n_fail++; $display("FAIL rr_rsp2 got=%b %h exp=0100 %h", rsp_valid, rsp_max, exp_mx[2]); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b1000 || rsp_flags !== exp_fl[3]) begin n_fail++; $display("FAIL rr_rsp3 got=%b %b exp=1000 %b", rsp_valid, rsp_flags, exp_fl[3]); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0010 || rsp_flags !== exp_fl[1]) begin n_fail++; $display("FAIL rr_rsp1 got=%b %b exp=0010 %b", rsp_valid, rsp_flags, exp_fl[1]); end
  endtask

  task automatic test_flags();
    step();
    req_valid = 4'b0001;
    req_a[0 +: W] = 32'h3F800000;
    req_b[0 +: W] = 32'h3F800000;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fl_g0a got=%b exp=0001", req_ready); end
    step();
    req_a[0 +: W] = 32'h7FC00000;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fl_g0b got=%b exp=0001", req_ready); end
    step(); req_valid = 4'b0000;
    step();
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0001 || rsp_flags !== 4'b0001 || rsp_max !== 32'h3F800000) begin
      n_fail++; $display("FAIL fl_eq got=%b %b %h exp=0001 0001 3f800000", rsp_valid, rsp_flags, rsp_max); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0001 || rsp_flags !== 4'b1000 || rsp_max !== 32'h7FC00000) begin
      n_fail++; $display("FAIL fl_nan got=%b %b %h exp=0001 1000 7fc00000", rsp_valid, rsp_flags, rsp_max); end
    step(); #1;
    n_chk++; if (rsp_valid !== 4'b0000 || rsp_flags !== 4'b1000) begin
      n_fail++; $display("FAIL fl_hold got=%b %b exp=0000 1000", rsp_valid, rsp_flags); end
  endtask

  task automatic test_reset_midop();
    step(); req_valid = 4'b0100; #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_g2 got=%b exp=0100", req_ready); end
    step(); req_valid = 4'b0010; #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_g1 got=%b exp=0010", req_ready); end
    step(); req_valid = 4'b0000; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      if (c > 3) step();
      req_valid = (c == 6) ? 4'b1111 : 4'b0000;
      #1;
      if (c == 6) begin
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
      end
      if (c < 10) begin
        n_chk++; if (rsp_valid !== 4'b0000 || err !== 1'b0) begin
          n_fail++; $display("FAIL mid_quiet c=%0d got=%b err=%b exp=0000 err=0", c, rsp_valid, err); end
      end else begin
        n_chk++; if (rsp_valid !== 4'b0001 || err !== 1'b0) begin
          n_fail++; $display("FAIL mid_new_rsp got=%b err=%b exp=0001 err=0", rsp_valid, err); end
      end
    end
  endtask

  task automatic test_stray();
    step(); inj = 1'b1; #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_pre got=%b exp=0", err); end
    step(); inj = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_sticky c=%0d got=%b exp=1", c, err); end
      step();
    end
    rst_n = 1'b0;
    step(); #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_clear got=%b exp=0", err); end
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_missing();
    core_mute = 1'b1;
    req_valid = 4'b0001;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL miss_grant got=%b exp=0001", req_ready); end
    step(); req_valid = 4'b0000;
    step();
    step(); #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL miss_pre got=%b exp=0", err); end
    step(); #1;
    n_chk++; if (err !== 1'b1 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL miss_err got=err %b rsp %b exp=err 1 rsp 0000", err, rsp_valid); end
    core_mute = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_skip();
    test_flags();
    test_reset_midop();
    test_stray();
    test_missing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
